// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin enqueue arbiter: FSM encoding and
// the bit layout of a queue entry ({last, src, data}).
package fifo_arb_pkg;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    typedef enum logic {
        S_IDLE   = ST_IDLE,
        S_LOCKED = ST_LOCKED
    } arb_state_e;

    function automatic int entry_src_lsb(input int width);
        return width;
    endfunction

    function automatic int entry_last_bit(input int width, input int idw);
        return width + idw;
    endfunction

    function automatic int entry_width(input int width, input int idw);
        return width + idw + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ. ptr is always kept below NREQ by the caller.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    always_comb begin
        int cand;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        cand       = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any && req[cand]) begin
                any              = 1'b1;
                gnt_idx          = IDW'(cand);
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Packet-aware round-robin N-to-1 arbiter feeding a first-word-fall-through
// queue; each stored entry carries the beat's last flag and source ID.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ  = 3,
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  flush,
    input  logic                  deq,
    output logic [WIDTH-1:0]      dout,
    output logic [IDW-1:0]        dout_src,
    output logic                  dout_last,
    output logic                  empty,
    output logic                  full,
    output logic [CW-1:0]         count
);

    localparam int AW       = $clog2(DEPTH);
    localparam int SRC_LSB  = entry_src_lsb(WIDTH);
    localparam int LAST_BIT = entry_last_bit(WIDTH, IDW);
    localparam int EW       = entry_width(WIDTH, IDW);

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [EW-1:0]    mem_q [DEPTH];

    logic [WIDTH-1:0] req_data_arr [NREQ];
    logic [NREQ-1:0]  pick_onehot;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic [NREQ-1:0]  grant_onehot;
    logic [IDW-1:0]   grant_idx;
    logic             pop_ok, space, enq_ok, pop, wr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_last;
    logic [EW-1:0]    wr_entry, rd_entry;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign req_data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (i == IDW'(NREQ - 1)) ? '0 : i + IDW'(1);
    endfunction

    rr_pick #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .gnt_onehot(pick_onehot),
        .gnt_idx   (pick_idx),
        .any       (pick_any)
    );

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign count  = count_q;
    assign pop_ok = deq & ~empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign space  = ~full | pop_ok;
    assign enq_ok = space & ~flush & rst_n;
    assign pop    = pop_ok & ~flush;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = pick_idx;
        if (state_q == S_IDLE) begin
            grant_onehot = pick_any ? pick_onehot : '0;
        end else begin
            grant_idx = owner_q;
            for (int i = 0; i < NREQ; i++) begin
                if (owner_q == IDW'(i)) begin
                    grant_onehot[i] = req_valid[i];
                end
            end
        end
    end

    assign req_ready = enq_ok ? grant_onehot : '0;
    assign wr        = |req_ready;

    always_comb begin
        wr_data = '0;
        wr_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                wr_data = req_data_arr[i];
                wr_last = req_last[i];
            end
        end
    end

    always_comb begin
        wr_entry                    = '0;
        wr_entry[WIDTH-1:0]         = wr_data;
        wr_entry[SRC_LSB +: IDW]    = grant_idx;
        wr_entry[LAST_BIT]          = wr_last;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            state_d = S_IDLE;
        end else if (wr) begin
            if (state_q == S_IDLE) begin
                if (!wr_last) begin
                    state_d = S_LOCKED;
                    owner_d = pick_idx;
                end else begin
                    rr_ptr_d = next_idx(pick_idx);
                end
            end else if (wr_last) begin
                state_d  = S_IDLE;
                rr_ptr_d = next_idx(owner_q);
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            case ({wr, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[tail_q] <= wr_entry;
        end
    end

    assign rd_entry  = mem_q[head_q];
    assign dout      = rd_entry[WIDTH-1:0];
    assign dout_src  = rd_entry[SRC_LSB +: IDW];
    assign dout_last = rd_entry[LAST_BIT];

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: stimulus pushes expected entries into a
// scoreboard queue, a negedge monitor checks every pop against it.
module tb_fifo_rr_arbiter;

    localparam int NREQ  = 3;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;
    localparam int CW    = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  flush;
    logic                  deq;
    logic [WIDTH-1:0]      dout;
    logic [IDW-1:0]        dout_src;
    logic                  dout_last;
    logic                  empty;
    logic                  full;
    logic [CW-1:0]         count;

    int checks = 0;
    int errors = 0;
    logic [WIDTH+IDW:0] sb[$];
    logic [WIDTH+IDW:0] mon_exp;

    fifo_rr_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .flush    (flush),
        .deq      (deq),
        .dout     (dout),
        .dout_src (dout_src),
        .dout_last(dout_last),
        .empty    (empty),
        .full     (full),
        .count    (count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && deq === 1'b1 && empty === 1'b0 && flush === 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got=%h required=none", {dout_last, dout_src, dout});
            end else begin
                mon_exp = sb.pop_front();
                if ({dout_last, dout_src, dout} !== mon_exp) begin
                    errors++;
                    $display("FAIL pop_entry got=%h required=%h", {dout_last, dout_src, dout}, mon_exp);
                end else begin
                    $display("pop last=%0d src=%0d data=%h", dout_last, dout_src, dout);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [WIDTH-1:0] d);
        req_valid[i]            = v;
        req_last[i]             = l;
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic exp_push(input int src, input logic last, input logic [WIDTH-1:0] d);
        logic [IDW-1:0] s;
        s = src[IDW-1:0];
        sb.push_back({last, s, d});
    endtask

    initial begin
        int g[4];
        g = '{0, 1, 2, 0};
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        flush     = 1'b0;
        deq       = 1'b0;

        // Reset state with all requesters asserting
        set_req(0, 1'b1, 1'b1, 8'h10);
        set_req(1, 1'b1, 1'b1, 8'h11);
        set_req(2, 1'b1, 1'b1, 8'h12);
        step();
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        step();

        // Test 1: three single-beat requesters, grants rotate 0,1,2,0
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t1_grant", 32'(req_ready), 32'(1 << g[k]));
            exp_push(g[k], 1'b1, 8'h10 + 8'(g[k]));
            step();
        end
        #1;
        check("t1_full_ready", 32'(req_ready), 32'h0);
        check("t1_full", 32'(full), 32'h1);
        check("t1_count", 32'(count), 32'h4);
        req_valid = '0;
        deq = 1'b1;
        repeat (4) step();
        deq = 1'b0;
        check("t1_drained", 32'(empty), 32'h1);
        req_valid = 3'b111;
        #1;
        check("t1_rrptr_1", 32'(req_ready), 32'h2);
        exp_push(1, 1'b1, 8'h11);
        step();
        req_valid = '0;
        deq = 1'b1;
        step();
        deq = 1'b0;
        check("t1_empty2", 32'(empty), 32'h1);

        // Test 2: requester 1 multi-beat packet holds the grant
        set_req(1, 1'b1, 1'b0, 8'hA1);
        #1;
        check("t2_a1", 32'(req_ready), 32'h2);
        exp_push(1, 1'b0, 8'hA1);
        step();
        set_req(0, 1'b1, 1'b1, 8'hB0);
        set_req(1, 1'b1, 1'b0, 8'hA2);
        #1;
        check("t2_a2", 32'(req_ready), 32'h2);
        exp_push(1, 1'b0, 8'hA2);
        step();
        set_req(1, 1'b0, 1'b0, 8'h00);
        #1;
        check("t2_owner_idle", 32'(req_ready), 32'h0);
        step();
        set_req(1, 1'b1, 1'b1, 8'hA3);
        #1;
        check("t2_a3", 32'(req_ready), 32'h2);
        exp_push(1, 1'b1, 8'hA3);
        step();
        set_req(1, 1'b0, 1'b0, 8'h00);
        #1;
        check("t2_req0_next", 32'(req_ready), 32'h1);
        exp_push(0, 1'b1, 8'hB0);
        step();
        set_req(0, 1'b0, 1'b0, 8'h00);
        check("t2_count", 32'(count), 32'h4);
        deq = 1'b1;
        repeat (4) step();
        deq = 1'b0;
        check("t2_drained", 32'(empty), 32'h1);

        // Test 3: fill to full, then push and pop in the same cycle
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 1'b1, 8'hC0 + 8'(k));
            #1;
            check("t3_fill", 32'(req_ready), 32'h1);
            exp_push(0, 1'b1, 8'hC0 + 8'(k));
            step();
        end
        set_req(0, 1'b1, 1'b1, 8'hC4);
        #1;
        check("t3_full_ready", 32'(req_ready), 32'h0);
        check("t3_full", 32'(full), 32'h1);
        check("t3_count", 32'(count), 32'h4);
        deq = 1'b1;
        #1;
        check("t3_ready_deq", 32'(req_ready), 32'h1);
        exp_push(0, 1'b1, 8'hC4);
        step();
        set_req(0, 1'b0, 1'b0, 8'h00);
        check("t3_count_hold", 32'(count), 32'h4);
        check("t3_full_hold", 32'(full), 32'h1);
        repeat (4) step();
        deq = 1'b0;
        check("t3_drained", 32'(count), 32'h0);

        // Test 4: streaming with deq held, pointers wrap
        deq = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_req(2, 1'b1, 1'b1, 8'hD0 + 8'(k));
            #1;
            check("t4_ready", 32'(req_ready), 32'h4);
            exp_push(2, 1'b1, 8'hD0 + 8'(k));
            step();
            check("t4_count", 32'(count), 32'h1);
        end
        set_req(2, 1'b0, 1'b0, 8'h00);
        step();
        deq = 1'b0;
        check("t4_count_end", 32'(count), 32'h0);
        check("t4_empty_end", 32'(empty), 32'h1);

        // Test 5: flush mid-packet drops the lock
        set_req(0, 1'b1, 1'b0, 8'hE1);
        set_req(1, 1'b1, 1'b1, 8'hF0);
        #1;
        check("t5_e1", 32'(req_ready), 32'h1);
        exp_push(0, 1'b0, 8'hE1);
        step();
        set_req(0, 1'b1, 1'b0, 8'hE2);
        #1;
        check("t5_e2", 32'(req_ready), 32'h1);
        exp_push(0, 1'b0, 8'hE2);
        step();
        set_req(0, 1'b1, 1'b0, 8'hE3);
        flush = 1'b1;
        #1;
        check("t5_ready_flush", 32'(req_ready), 32'h0);
        step();
        flush = 1'b0;
        sb.delete();
        check("t5_empty", 32'(empty), 32'h1);
        check("t5_count", 32'(count), 32'h0);
        set_req(0, 1'b0, 1'b0, 8'h00);
        #1;
        check("t5_regrant", 32'(req_ready), 32'h2);
        exp_push(1, 1'b1, 8'hF0);
        step();
        set_req(1, 1'b0, 1'b0, 8'h00);
        check("t5_count1", 32'(count), 32'h1);
        deq = 1'b1;
        step();
        deq = 1'b0;

        // Test 6: asynchronous reset with entries queued
        for (int k = 0; k < 3; k++) begin
            set_req(2, 1'b1, 1'b1, 8'h60 + 8'(k));
            #1;
            check("t6_fill", 32'(req_ready), 32'h4);
            exp_push(2, 1'b1, 8'h60 + 8'(k));
            step();
        end
        set_req(2, 1'b0, 1'b0, 8'h00);
        set_req(1, 1'b1, 1'b1, 8'h71);
        check("t6_pre_count", 32'(count), 32'h3);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("t6_empty", 32'(empty), 32'h1);
        check("t6_full", 32'(full), 32'h0);
        check("t6_count", 32'(count), 32'h0);
        check("t6_ready", 32'(req_ready), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        check("t6_after_reset", 32'(req_ready), 32'h2);
        exp_push(1, 1'b1, 8'h71);
        step();
        set_req(1, 1'b0, 1'b0, 8'h00);
        deq = 1'b1;
        step();
        deq = 1'b0;
        check("t6_drained", 32'(empty), 32'h1);
        check("sb_leftover", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin, packet-aware N-to-1 enqueue arbiter with built-in FIFO storage. Up to NREQ producers each present a valid/ready beat stream tagged with a last flag. The block grants one producer at a time, holds the grant until that producer's last beat, and writes every accepted beat together with its source ID into a first-word-fall-through queue. It sits between multiple bus-side producers (UART/SD/DMA paths) and a single consumer that pops with deq.

## Interface
- NREQ, 3: number of requesters, 2..8
- WIDTH, 32: data width per beat
- DEPTH, 16: queue entries, power of two ≥ 2; all DEPTH entries usable
- IDW, derived $clog2(NREQ) (min 1): source-ID width
- CW, derived $clog2(DEPTH)+1: occupancy width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester beat valid
- req_data  in  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- req_last  in  NREQ  beat is the final beat of its packet
- req_ready  out  NREQ  beat accepted this cycle (one-hot or zero)
- flush  in  1  synchronous clear of queue and lock
- deq  in  1  pop head entry
- dout  out  WIDTH  head data (valid when !empty)
- dout_src  out  IDW  head source ID
- dout_last  out  1  head last flag
- empty  out  1  queue holds 0 entries
- full  out  1  queue holds DEPTH entries
- count  out  CW  current occupancy, 0..DEPTH

## Operation
- State machine: IDLE (no owner) and LOCKED (owner register valid).
- space = !full | (deq & !empty). Enqueue is possible only when space=1, flush=0, and rst_n=1.
- IDLE: pick = first i with req_valid[i]=1 searching rr_ptr, rr_ptr+1, … mod NREQ. If space, req_ready[pick]=1 and the beat is written.
  - Beat with last=0: go LOCKED, owner<=pick.
  - Beat with last=1: stay IDLE, rr_ptr<=(pick+1) mod NREQ.
- LOCKED: only the owner may get ready, and only when req_valid[owner]&space. All other ready bits are 0, even if the owner is idle.
  - Accepted beat with last=1: go IDLE, rr_ptr<=(owner+1) mod NREQ.
- Entry stored = {last, src, data}. tail advances on write; head advances on deq&!empty. deq while empty is ignored.
- count: +1 on write only, -1 on pop only, unchanged on both. full = (count==DEPTH), empty = (count==0).
- Pointers are log2(DEPTH) bits and wrap naturally.
- flush: head, tail and count clear; state<=IDLE; rr_ptr is kept; req_ready=0; a same-cycle deq is ignored.
- Reset (async, rst_n=0): state IDLE, rr_ptr 0, head/tail/count 0, empty=1, full=0, req_ready=0. Storage contents are undefined; dout is don't-care while empty.
- Reset mid-packet drops the lock and discards all queued beats.

## Timing
- req_ready is combinational from req_valid, state, count and deq. Requesters must not derive valid from ready.
- Write→visible: an entry written at edge k gives empty=0 and valid dout after edge k; the consumer can pop in cycle k+1.
- Fall-through: dout, dout_src and dout_last are combinational reads of the entry at head. Pop at edge k presents the next entry after edge k.
- Throughput: one beat per cycle sustained, including at full with simultaneous deq.
- Grant switches take zero idle cycles: a new packet may start in the cycle after a last beat.

## Structure
- Shared package (fifo_arb_pkg): state encoding localparams ST_IDLE=1'b0 and ST_LOCKED=1'b1, plus an entry-layout helper (field offsets for last/src/data).
- One sub-module: rr_pick, combinational. Inputs req[NREQ] and ptr[IDW]; outputs gnt_onehot[NREQ], gnt_idx[IDW] and any.
- Storage is an internal reg array. Pointers and count use async reset.

## Test plan
(NREQ=3, WIDTH=8, DEPTH=4, deq=0 unless noted.)
- Three single-beat packets, all valid and last in cycle 0 and held: grants go 0,1,2,0. The popped sequence shows src 0,1,2 and rr_ptr returns to 1.
- Requester 1 sends a 3-beat packet (A1,A2,A3-last) while requester 0 is continuously valid: req_ready[0]=0 until A3 is accepted, then requester 0 is granted the next cycle. The queue holds A1,A2,A3 contiguously.
- Fill 4 beats with no deq: full=1, count=4, req_ready=0. Then assert deq with a valid requester: one pop and one push occur in the same cycle, and count stays 4.
- 10 beats at 1/cycle with deq held high: the pointers wrap twice, data pops in order, and count never exceeds 1.
- Packet owner asserts flush mid-packet, after 2 beats: empty=1 and count=0 the next cycle, state is IDLE, and another requester is granted the following cycle.
- rst_n pulled low asynchronously mid-cycle with 3 entries queued: empty=1, full=0, count=0 and req_ready=0 immediately, before the next clk edge.
